branch_sequencer: RTL and testbench
===================================

# branch_sequencer

Control-unit sequencer for the conditional branch instructions: brzr, brnz, brpl and brmi. It is the consumer side of the condition flip-flop (CON FF). It latches the branch condition field, pulses CON_in while Ra is on the bus, samples the CON result, and conditionally drives the PC ← PC + C(sign-extended) micro-steps. It sits beside the main control FSM, which hands it a branch with `start` and waits for `done`. It also keeps saturating taken / not-taken counters for debug.

## Interface
- `CNT_W`, default 16: width of the taken / not-taken statistics counters.
- `clock` input 1: single system clock, rising-edge.
- `clear` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request from the main control FSM; the IR holds a branch instruction.
- `cond_in` input 2: IR condition field C2[1:0] (00 zero, 01 nonzero, 10 ≥0, 11 <0).
- `con_out` input 1: CON FF output; valid the cycle after `con_in` was high.
- `con_cond` output 2: latched condition field, driven to the CON FF instruction-bit inputs; held for the whole operation.
- `con_in` output 1: CON FF load enable.
- `con_clear` output 1: CON FF clear.
- `gra` output 1: select Ra as the register-file source.
- `r_out` output 1: register-file bus drive enable.
- `pc_out` output 1: PC bus drive enable.
- `y_in` output 1: Y register load.
- `c_out` output 1: sign-extended constant bus drive enable.
- `alu_add` output 1: ALU opcode select ADD.
- `z_in` output 1: Z register load.
- `z_low_out` output 1: Z[31:0] bus drive enable.
- `pc_in` output 1: PC load.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle completion pulse.
- `taken` output 1: result of the last completed branch; held until the next DONE.
- `taken_cnt` output CNT_W: saturating count of taken branches.
- `not_taken_cnt` output CNT_W: saturating count of not-taken branches.

## Operation
- States: IDLE, EVAL, CHECK, ADDR_Y, ADDR_Z, COMMIT, DONE. All state and outputs are registered. Control strobes are Moore outputs decoded from the state.
- IDLE: all strobes 0. If `start`=1, latch `cond_in` into `con_cond` and go to EVAL. If `start`=0, stay in IDLE.
- EVAL: `gra`=`r_out`=`con_in`=1. Next state is CHECK.
- CHECK: all strobes 0. Sample `con_out` into internal `take_q`. If `con_out`=1, go to ADDR_Y; otherwise go to DONE.
- ADDR_Y: `pc_out`=`y_in`=1. Next state is ADDR_Z.
- ADDR_Z: `c_out`=`alu_add`=`z_in`=1. Next state is COMMIT.
- COMMIT: `z_low_out`=`pc_in`=1. Next state is DONE.
- DONE: `done`=1 and `con_clear`=1.
  - `taken` ← `take_q`.
  - Increment `taken_cnt` if `take_q`=1, else increment `not_taken_cnt`. Increment only when the counter is below all-ones; a counter at all-ones holds.
  - Next state is IDLE.
- `start` while `busy`=1 is ignored: no queueing, and `con_cond` does not change.
- `pc_in` is never asserted on a not-taken path.
- At most one bus driver is active in any state: `r_out`, `pc_out`, `c_out` and `z_low_out` are mutually exclusive.
- `con_cond` changes only on IDLE→EVAL.

## Timing
- Take cycle 0 as the edge that samples `start`=1 in IDLE.
- Taken path: EVAL at cycle 1, CHECK 2, ADDR_Y 3, ADDR_Z 4, COMMIT 5, DONE 6. `done` is high during cycle 6. Latency is 6 cycles.
- Not-taken path: EVAL at cycle 1, CHECK 2, DONE 3. Latency is 3 cycles.
- A new `start` is accepted in the first IDLE cycle after DONE. Minimum issue interval is 7 cycles (taken) or 4 cycles (not taken).
- `clear`=1 at any edge, including mid-operation:
  - state returns to IDLE;
  - all strobes, `busy`, `done`, `taken`, `con_cond`, `taken_cnt` and `not_taken_cnt` reset to 0;
  - `con_clear` is 1 for the cycle after the clearing edge, so the CON FF is also flushed;
  - `clear` has priority over `start`.
- With `clear` and `start` both high, `start` is dropped.
- No combinational path from any input to any output.

## Test plan
- brzr taken: `cond_in`=00, Ra=0 so the model CON FF returns 1. Require:
  - `pc_in` high only at cycle 5;
  - `done` at cycle 6;
  - `taken`=1, `taken_cnt`=1;
  - PC = PC+C in the bus model.
- brnz not taken: `cond_in`=01, Ra=0. Require:
  - `done` at cycle 3;
  - `pc_in`, `y_in`, `z_in` never asserted;
  - `not_taken_cnt`=1, `taken`=0.
- brmi and brpl on Ra=0x80000000: brmi (`cond_in`=11) is taken; brpl (`cond_in`=10) is not taken. Require `con_cond` to stay 11 then 10 throughout each operation even when `cond_in` toggles.
- `start` held high for 10 cycles: exactly one branch executes, plus a second starting at the IDLE cycle after DONE. Check `busy` and the one-hot bus-driver invariant every cycle.
- Assert `clear` in ADDR_Z of a taken branch. Require:
  - next cycle is IDLE with all outputs 0;
  - `con_clear`=1 for one cycle;
  - `pc_in` never pulses;
  - counters are 0.
- Saturation: use `CNT_W`=2 and run 5 taken branches. Require `taken_cnt`=3 after the 3rd, 4th and 5th.

Source files
------------

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer (brzr/brnz/brpl/brmi): drives CON FF
// evaluation and the PC <= PC + C micro-steps, keeps debug counters.
//
// Ports:
//   clock, clear        : clock and synchronous active-high reset
//   start, cond_in      : branch request and IR condition field C2[1:0]
//   con_out             : CON FF result (valid the cycle after con_in)
//   con_cond            : latched condition field for the CON FF
//   con_in, con_clear   : CON FF load / clear
//   gra, r_out          : Ra onto the bus
//   pc_out, y_in        : PC onto the bus, load Y
//   c_out, alu_add, z_in: constant onto the bus, ADD, load Z
//   z_low_out, pc_in    : Z onto the bus, load PC
//   busy, done, taken   : status; taken holds the last completed result
//   taken_cnt,
//   not_taken_cnt       : saturating statistics counters
module branch_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       cond_in,
  input  logic             con_out,
  output logic [1:0]       con_cond,
  output logic             con_in,
  output logic             con_clear,
  output logic             gra,
  output logic             r_out,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             z_low_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_CHECK,
    S_ADDR_Y,
    S_ADDR_Z,
    S_COMMIT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       cond_q;
  logic             take_q;
  logic             taken_q;
  logic             clr_q;
  logic [CNT_W-1:0] tcnt_q;
  logic [CNT_W-1:0] ncnt_q;

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_EVAL;
      S_EVAL:   state_d = S_CHECK;
      S_CHECK:  state_d = con_out ? S_ADDR_Y : S_DONE;
      S_ADDR_Y: state_d = S_ADDR_Z;
      S_ADDR_Z: state_d = S_COMMIT;
      S_COMMIT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Condition latch, branch result and statistics.
  // clr_q stretches a clear into one flush cycle for the CON FF.
  always_ff @(posedge clock) begin
    if (clear) begin
      cond_q  <= 2'b00;
      take_q  <= 1'b0;
      taken_q <= 1'b0;
      clr_q   <= 1'b1;
      tcnt_q  <= '0;
      ncnt_q  <= '0;
    end else begin
      clr_q <= 1'b0;
      if (state_q == S_IDLE && start) begin
        cond_q <= cond_in;
      end
      if (state_q == S_CHECK) begin
        take_q <= con_out;
      end
      if (state_q == S_DONE) begin
        taken_q <= take_q;
        if (take_q) begin
          if (tcnt_q != '1) tcnt_q <= tcnt_q + CNT_W'(1);
        end else begin
          if (ncnt_q != '1) ncnt_q <= ncnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Moore strobe decode
  always_comb begin
    con_in    = 1'b0;
    con_clear = clr_q;
    gra       = 1'b0;
    r_out     = 1'b0;
    pc_out    = 1'b0;
    y_in      = 1'b0;
    c_out     = 1'b0;
    alu_add   = 1'b0;
    z_in      = 1'b0;
    z_low_out = 1'b0;
    pc_in     = 1'b0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  ;
      S_EVAL: begin
        gra    = 1'b1;
        r_out  = 1'b1;
        con_in = 1'b1;
      end
      S_CHECK: ;
      S_ADDR_Y: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
      end
      S_ADDR_Z: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
      end
      S_COMMIT: begin
        z_low_out = 1'b1;
        pc_in     = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        con_clear = 1'b1;
      end
      default: ;
    endcase
  end

  assign con_cond      = cond_q;
  assign taken         = taken_q;
  assign taken_cnt     = tcnt_q;
  assign not_taken_cnt = ncnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: bus/CON FF model around the DUT plus a
// transaction-level reference checked every cycle, and directed cases.
module tb_branch_sequencer;

  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             clear;
  logic             start;
  logic [1:0]       cond_in;
  logic             con_out;
  logic [1:0]       con_cond;
  logic             con_in;
  logic             con_clear;
  logic             gra;
  logic             r_out;
  logic             pc_out;
  logic             y_in;
  logic             c_out;
  logic             alu_add;
  logic             z_in;
  logic             z_low_out;
  logic             pc_in;
  logic             busy;
  logic             done;
  logic             taken;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] not_taken_cnt;

  branch_sequencer #(.CNT_W(CNT_W)) dut (
    .clock         (clock),
    .clear         (clear),
    .start         (start),
    .cond_in       (cond_in),
    .con_out       (con_out),
    .con_cond      (con_cond),
    .con_in        (con_in),
    .con_clear     (con_clear),
    .gra           (gra),
    .r_out         (r_out),
    .pc_out        (pc_out),
    .y_in          (y_in),
    .c_out         (c_out),
    .alu_add       (alu_add),
    .z_in          (z_in),
    .z_low_out     (z_low_out),
    .pc_in         (pc_in),
    .busy          (busy),
    .done          (done),
    .taken         (taken),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );

  always #5 clock = ~clock;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic cond_true(input logic [1:0] c,
                                     input logic [31:0] v);
    case (c)
      2'b00:   return v == 32'd0;
      2'b01:   return v != 32'd0;
      2'b10:   return v[31] == 1'b0;
      default: return v[31] == 1'b1;
    endcase
  endfunction

  // ---------------- bus / datapath model ----------------
  logic [31:0] ra_val = 32'd0;
  logic [31:0] c_val  = 32'hFFFF_FFF8;
  logic [31:0] pc_r   = 32'h100;
  logic [31:0] y_r    = 32'd0;
  logic [31:0] z_r    = 32'd0;
  logic        con_ff = 1'b0;

  logic [31:0] s_bus = 32'd0;
  logic [1:0]  s_cond = 2'b00;
  logic s_ci = 0, s_cc = 0, s_y = 0, s_z = 0, s_add = 0, s_pc = 0;

  assign con_out = con_ff;

  always @(negedge clock) begin
    s_bus  <= ((r_out && gra) ? ra_val : 32'd0) |
              (pc_out ? pc_r : 32'd0) |
              (c_out ? c_val : 32'd0) |
              (z_low_out ? z_r : 32'd0);
    s_ci   <= con_in;
    s_cc   <= con_clear;
    s_cond <= con_cond;
    s_y    <= y_in;
    s_z    <= z_in;
    s_add  <= alu_add;
    s_pc   <= pc_in;
  end

  always @(posedge clock) begin
    if (s_cc) con_ff <= 1'b0;
    else if (s_ci) con_ff <= cond_true(s_cond, s_bus);
    if (s_y) y_r <= s_bus;
    if (s_z) z_r <= s_add ? y_r + s_bus : s_bus;
    if (s_pc) pc_r <= s_bus;
  end

  // ---------------- transaction-level reference ----------------
  // m_t: cycles since acceptance (-1 when idle); an op lasts 6 or 3.
  int          m_t = -1;
  logic        m_tk = 1'b0;
  logic        m_taken = 1'b0;
  logic        m_clr = 1'b0;
  logic [1:0]  m_cc = 2'b00;
  int          m_tc = 0;
  int          m_nc = 0;
  logic [31:0] m_pc = 32'h100;

  always @(posedge clock) begin
    if (clear) begin
      m_t     <= -1;
      m_cc    <= 2'b00;
      m_taken <= 1'b0;
      m_tc    <= 0;
      m_nc    <= 0;
      m_clr   <= 1'b1;
    end else begin
      m_clr <= 1'b0;
      if (m_t < 0) begin
        if (start) begin
          m_t  <= 1;
          m_cc <= cond_in;
          m_tk <= cond_true(cond_in, ra_val);
        end
      end else if (m_t == (m_tk ? 6 : 3)) begin
        m_t     <= -1;
        m_taken <= m_tk;
        if (m_tk) begin
          if (m_tc < MAXC) m_tc <= m_tc + 1;
          m_pc <= m_pc + c_val;
        end else if (m_nc < MAXC) begin
          m_nc <= m_nc + 1;
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // {gra,r_out,con_in,pc_out,y_in,c_out,alu_add,z_in,z_low_out,pc_in,done}
  function automatic logic [10:0] sched(input int t, input logic tk);
    logic [10:0] v;
    v = '0;
    if (t == 1) v[10:8] = 3'b111;
    if (tk && t == 3) v[7:6] = 2'b11;
    if (tk && t == 4) v[5:3] = 3'b111;
    if (tk && t == 5) v[2:1] = 2'b11;
    if (t > 0 && t == (tk ? 6 : 3)) v[0] = 1'b1;
    return v;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("strobes", {21'd0, gra, r_out, con_in, pc_out, y_in, c_out,
                      alu_add, z_in, z_low_out, pc_in, done},
          {21'd0, sched(m_t, m_tk)});
      chk("busy", {31'd0, busy}, {31'd0, m_t > 0});
      chk("con_clear", {31'd0, con_clear},
          {31'd0, m_clr || sched(m_t, m_tk)[0]});
      chk("con_cond", {30'd0, con_cond}, {30'd0, m_cc});
      chk("taken", {31'd0, taken}, {31'd0, m_taken});
      chk("taken_cnt", 32'(taken_cnt), 32'(m_tc));
      chk("not_taken_cnt", 32'(not_taken_cnt), 32'(m_nc));
      chk("one_driver",
          {31'd0, ($countones({r_out, pc_out, c_out, z_low_out}) <= 1)},
          32'd1);
      if (m_t < 0) chk("pc", pc_r, m_pc);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic op(input logic [1:0] c, input logic [31:0] ra,
                    input bit toggle, output int lat, output int pcp);
    @(negedge clock);
    ra_val  = ra;
    cond_in = c;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat   = -1;
    pcp   = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clock);
      if (toggle) cond_in = 2'($urandom);
      if (pc_in) pcp++;
      if (done) begin
        lat = k;
        break;
      end
    end
    @(negedge clock);
  endtask

  int lat, pcp, nd;
  logic [31:0] pc_save;

  initial begin
    clear   = 1'b1;
    start   = 1'b0;
    cond_in = 2'b00;
    @(posedge clock);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_con_clear", {31'd0, con_clear}, 32'd1);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    clear = 1'b0;

    // brzr taken
    op(2'b00, 32'd0, 1'b0, lat, pcp);
    chk("brzr_latency", lat, 32'd6);
    chk("brzr_pc_in_pulses", pcp, 32'd1);
    chk("brzr_taken", {31'd0, taken}, 32'd1);
    chk("brzr_taken_cnt", 32'(taken_cnt), 32'd1);
    chk("brzr_pc", pc_r, 32'h0000_00F8);

    // brnz not taken
    op(2'b01, 32'd0, 1'b0, lat, pcp);
    chk("brnz_latency", lat, 32'd3);
    chk("brnz_pc_in_pulses", pcp, 32'd0);
    chk("brnz_taken", {31'd0, taken}, 32'd0);
    chk("brnz_not_taken_cnt", 32'(not_taken_cnt), 32'd1);

    // brmi / brpl on negative Ra, cond_in toggling mid-op
    op(2'b11, 32'h8000_0000, 1'b1, lat, pcp);
    chk("brmi_latency", lat, 32'd6);
    chk("brmi_taken", {31'd0, taken}, 32'd1);
    chk("brmi_pc", pc_r, 32'h0000_00F0);
    op(2'b10, 32'h8000_0000, 1'b1, lat, pcp);
    chk("brpl_latency", lat, 32'd3);
    chk("brpl_taken", {31'd0, taken}, 32'd0);

    // start held for 10 cycles: two taken branches back to back
    @(negedge clock);
    ra_val  = 32'd0;
    cond_in = 2'b00;
    start   = 1'b1;
    nd = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      if (k == 10) start = 1'b0;
      if (done) nd++;
    end
    chk("held_start_done_count", nd, 32'd2);

    // clear during ADDR_Z of a taken branch
    pc_save = pc_r;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    chk("addr_z_z_in", {31'd0, z_in}, 32'd1);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_con_clear", {31'd0, con_clear}, 32'd1);
    chk("clr_pc_in", {31'd0, pc_in}, 32'd0);
    chk("clr_counts", {16'(taken_cnt), 16'(not_taken_cnt)}, 32'd0);
    @(negedge clock);
    chk("clr_con_clear_once", {31'd0, con_clear}, 32'd0);
    chk("clr_pc_kept", pc_r, pc_save);

    // saturation with a 2-bit counter
    for (int i = 1; i <= 5; i++) begin
      op(2'b00, 32'd0, 1'b0, lat, pcp);
      chk("sat_taken_cnt", 32'(taken_cnt), (i < 3) ? i : 3);
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      clear   = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 2) == 0);
      cond_in = 2'($urandom);
      if (m_t < 0) begin
        case ($urandom_range(0, 3))
          0:       ra_val = 32'd0;
          1:       ra_val = 32'h8000_0000;
          2:       ra_val = 32'($urandom_range(1, 9));
          default: ra_val = $urandom;
        endcase
      end
    end
    @(negedge clock);
    clear = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
